// File: rtl/serial_adder.sv
// serial_adder
//   Bit-serial adder: adds two WIDTH-bit operands plus a carry-in, one bit
//   per clock, through a single full-adder cell and a carry flop. A
//   start/busy/done handshake frames each operation. After an operation is
//   accepted, busy stays high for exactly WIDTH cycles. Then done pulses for
//   one cycle. A start seen in the DONE cycle launches the next operation
//   with no idle gap.
//
// Ports
//   clk    in   1      clock, rising edge
//   rst    in   1      asynchronous active-high reset
//   start  in   1      request, sampled when not busy
//   a      in   WIDTH  operand A, captured on accepted start
//   b      in   WIDTH  operand B, captured on accepted start
//   cin    in   1      carry-in, captured on accepted start
//   busy   out  1      addition in progress
//   done   out  1      one-cycle pulse; sum/cout valid from this cycle
//   sum    out  WIDTH  result; bits enter at the MSB and move toward the LSB
//   cout   out  1      final carry-out
//
// All outputs come straight from flops.

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // The single full-adder cell works on the current LSBs and the carry flop.
  logic s_bit;
  logic c_next;
  assign s_bit  = a_q[0] ^ b_q[0] ^ carry_q;
  assign c_next = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

  // The new sum bit enters at the MSB. After WIDTH shifts, bit 0 of the
  // result has reached the LSB. A one-bit result register has nothing to
  // shift, so WIDTH=1 needs its own case.
  logic [WIDTH-1:0] sum_shift;
  generate
    if (WIDTH == 1) begin : g_w1
      assign sum_shift = s_bit;
    end else begin : g_wn
      assign sum_shift = {s_bit, sum_q[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = c_next;
        sum_d   = sum_shift;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          cout_d  = c_next;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // A start in this cycle begins the next operation with no gap.
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Register busy/done from the next state so that both are flop outputs.
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder
//   Bench for serial_adder with two instances: WIDTH=8 and WIDTH=1.
//   Expected results come from plain integer addition, {cout,sum} = a+b+cin.
//   Expected handshake timing is: busy for WIDTH cycles after the accepting
//   edge, then a single done cycle.

module tb_serial_adder;

  logic       clk;
  logic       rst;

  logic       start8;
  logic [7:0] a8, b8;
  logic       cin8;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;

  logic       start1;
  logic [0:0] a1, b1;
  logic       cin1;
  logic       busy1, done1, cout1;
  logic [0:0] sum1;

  int vectors;
  int miscompares;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // One WIDTH=8 operation, with timing checked on every cycle. With poke
  // set, a stray start carrying a=8'h11 is driven during the 3rd busy
  // cycle; the bench expects it to be ignored.
  task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic ci, input bit poke);
    logic [8:0] expv;
    expv = {1'b0, av} + {1'b0, bv} + {8'd0, ci};
    @(negedge clk);
    start8 = 1'b1; a8 = av; b8 = bv; cin8 = ci;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    check("busy8_first", busy8, 1);
    check("done8_first", done8, 0);
    for (int i = 1; i < 8; i++) begin
      if (poke && i == 3) begin
        start8 = 1'b1; a8 = 8'h11;
      end else begin
        start8 = 1'b0;
      end
      @(negedge clk);
      check("busy8_run", busy8, 1);
      check("done8_run", done8, 0);
    end
    @(negedge clk);
    check("done8_pulse", done8, 1);
    check("busy8_at_done", busy8, 0);
    check("sum8", sum8, expv[7:0]);
    check("cout8", cout8, expv[8]);
    $display("op8 a=%02h b=%02h cin=%0d poke=%0d -> sum=%02h cout=%0d (exp %02h %0d)",
             av, bv, ci, poke, sum8, cout8, expv[7:0], expv[8]);
    @(negedge clk);
    check("done8_single", done8, 0);
    check("busy8_after", busy8, 0);
    check("sum8_hold", sum8, expv[7:0]);
    check("cout8_hold", cout8, expv[8]);
  endtask

  // One WIDTH=1 operation: a single busy cycle, then done.
  task automatic op1(input logic av, input logic bv, input logic ci);
    logic [1:0] expv;
    expv = {1'b0, av} + {1'b0, bv} + {1'b0, ci};
    @(negedge clk);
    start1 = 1'b1; a1 = av; b1 = bv; cin1 = ci;
    @(negedge clk);
    start1 = 1'b0;
    check("busy1", busy1, 1);
    check("done1_early", done1, 0);
    @(negedge clk);
    check("done1", done1, 1);
    check("busy1_at_done", busy1, 0);
    check("sum1", sum1, expv[0]);
    check("cout1", cout1, expv[1]);
    $display("op1 a=%0d b=%0d cin=%0d -> sum=%0d cout=%0d (exp %0d %0d)",
             av, bv, ci, sum1, cout1, expv[0], expv[1]);
  endtask

  initial begin
    logic [8:0] exp_first, exp_second;
    int gap;
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy8", busy8, 0);
    check("rst_done8", done8, 0);
    check("rst_sum8", sum8, 0);
    check("rst_cout8", cout8, 0);
    check("rst_busy1", busy1, 0);
    check("rst_done1", done1, 0);
    rst = 1'b0;

    // Half-adder truth table through the WIDTH=1 instance, then cin=1.
    op1(1'b0, 1'b0, 1'b0);
    op1(1'b0, 1'b1, 1'b0);
    op1(1'b1, 1'b0, 1'b0);
    op1(1'b1, 1'b1, 1'b0);
    op1(1'b1, 1'b1, 1'b1);
    op1(1'b0, 1'b0, 1'b1);

    // Directed WIDTH=8 cases.
    op8(8'd100, 8'd27, 1'b0, 1'b0);
    op8(8'hFF, 8'h01, 1'b0, 1'b0);
    op8(8'hA5, 8'h5A, 1'b1, 1'b0);
    op8(8'h00, 8'h00, 1'b0, 1'b0);
    op8(8'hFF, 8'hFF, 1'b1, 1'b0);
    op8(8'h3C, 8'h42, 1'b0, 1'b1);

    // Back-to-back: start is held through the DONE cycle. The done pulses
    // must be WIDTH+1 cycles apart, with no idle cycle between operations.
    exp_first  = 9'h0C3 + 9'h05A + 9'd1;
    exp_second = 9'h081 + 9'h0F0 + 9'd0;
    @(negedge clk);
    start8 = 1'b1; a8 = 8'hC3; b8 = 8'h5A; cin8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    for (int i = 1; i < 8; i++) @(negedge clk);
    start8 = 1'b1; a8 = 8'h81; b8 = 8'hF0; cin8 = 1'b0;
    @(negedge clk);
    check("b2b_done_first", done8, 1);
    check("b2b_sum_first", sum8, exp_first[7:0]);
    check("b2b_cout_first", cout8, exp_first[8]);
    $display("b2b first  -> sum=%02h cout=%0d (exp %02h %0d)", sum8, cout8, exp_first[7:0], exp_first[8]);
    gap = 0;
    @(negedge clk);
    start8 = 1'b0;
    gap++;
    check("b2b_no_gap_busy", busy8, 1);
    while (done8 !== 1'b1 && gap < 20) begin
      @(negedge clk);
      gap++;
    end
    check("b2b_gap", gap, 9);
    check("b2b_sum_second", sum8, exp_second[7:0]);
    check("b2b_cout_second", cout8, exp_second[8]);
    $display("b2b second -> sum=%02h cout=%0d gap=%0d (exp %02h %0d gap 9)",
             sum8, cout8, gap, exp_second[7:0], exp_second[8]);
    @(negedge clk);

    // Asynchronous reset between edges in the middle of RUN.
    start8 = 1'b1; a8 = 8'h77; b8 = 8'h99; cin8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy8", busy8, 0);
    check("arst_done8", done8, 0);
    check("arst_sum8", sum8, 0);
    check("arst_cout8", cout8, 0);
    $display("async reset mid-run -> busy=%0d done=%0d sum=%02h cout=%0d", busy8, done8, sum8, cout8);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("arst_no_done", done8, 0);
    end
    op8(8'h77, 8'h99, 1'b1, 1'b0);

    // Randomized operations, some with a stray start during RUN.
    for (int n = 0; n < 24; n++) begin
      op8(8'($urandom), 8'($urandom), 1'($urandom), bit'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
